// File: rtl/m10_egrs_spi_slave.sv
// rtl/m10_egrs_spi_slave.sv - Oversampled SPI slave for the PMCI-to-MAX10 egress link
module m10_egrs_spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       egrs_spi_clk,
    input  logic       egrs_spi_csn,
    input  logic       egrs_spi_mosi,
    output logic       egrs_spi_miso,
    output logic       egrs_spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_sof,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       frame_end,
    output logic       frame_err,
    output logic       rx_overflow,
    input  logic       ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   csn_prev;
    logic                   sclk_s;
    logic                   csn_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   csn_rise;
    logic                   csn_fall;

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic       sof_pend;
    logic       push_req;
    logic [7:0] push_data;
    logic       push_sof;
    logic [7:0] tx_shift;
    logic       first_fall;

    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        wr_en;
    logic        ovf_set;
    logic [8:0]  rd_entry;

    // Synchronize the SPI pins; sync flops clear to 0 so that a reset taken while
    // csn is low keeps the FSM parked until csn is genuinely seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            csn_sync  <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            csn_prev  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], egrs_spi_clk};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], egrs_spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], egrs_spi_mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            csn_prev  <= csn_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign csn_rise  = csn_s & ~csn_prev;
    assign csn_fall  = ~csn_s & csn_prev;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame state transitions; WAIT_IDLE refuses to join a frame already in progress.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_IDLE: if (csn_s)    state_next = IDLE;
            IDLE:      if (csn_fall) state_next = ACTIVE;
            ACTIVE:    if (csn_rise) state_next = IDLE;
            default:   state_next = WAIT_IDLE;
        endcase
    end

    // Bit-level shift engine: rx deserializer, tx serializer and frame-end pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            rx_shift   <= 7'd0;
            sof_pend   <= 1'b1;
            push_req   <= 1'b0;
            push_data  <= 8'h00;
            push_sof   <= 1'b0;
            tx_shift   <= 8'h00;
            first_fall <= 1'b0;
            tx_ready   <= 1'b0;
            frame_end  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            tx_ready  <= 1'b0;
            frame_end <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE && csn_fall) begin
                tx_shift   <= tx_valid ? tx_data : IDLE_BYTE;
                tx_ready   <= tx_valid;
                first_fall <= 1'b1;
                bit_cnt    <= 3'd0;
                sof_pend   <= 1'b1;
            end else if (state == ACTIVE) begin
                if (csn_rise) begin
                    frame_end <= 1'b1;
                    frame_err <= (bit_cnt != 3'd0);
                    bit_cnt   <= 3'd0;
                    sof_pend  <= 1'b1;
                end else if (sclk_rise) begin
                    rx_shift <= {rx_shift[5:0], mosi_s};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        push_req  <= 1'b1;
                        push_data <= {rx_shift, mosi_s};
                        push_sof  <= sof_pend;
                        sof_pend  <= 1'b0;
                    end
                end else if (sclk_fall) begin
                    first_fall <= 1'b0;
                    if (bit_cnt == 3'd0 && !first_fall) begin
                        tx_shift <= tx_valid ? tx_data : IDLE_BYTE;
                        tx_ready <= tx_valid;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = rx_valid && rx_ready;
    assign wr_en      = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;

    // FIFO storage; contents are only observed through the valid-gated read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {push_sof, push_data};
        end
    end

    // FIFO pointers and sticky overflow; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (ovf_set) begin
                rx_overflow <= 1'b1;
            end else if (ovf_clr) begin
                rx_overflow <= 1'b0;
            end
        end
    end

    assign rd_entry         = mem[rd_ptr[AW-1:0]];
    assign rx_valid         = !fifo_empty;
    assign rx_data          = rx_valid ? rd_entry[7:0] : 8'h00;
    assign rx_sof           = rx_valid ? rd_entry[8] : 1'b0;
    assign egrs_spi_miso_oe = (state == ACTIVE);
    assign egrs_spi_miso    = (state == ACTIVE) ? tx_shift[7] : 1'b0;

endmodule
